// File: rtl/spi_slave_shift_pkg.sv
// Shared sizes and state encoding for the SPI slave shift engine.
package spi_slave_shift_pkg;
  localparam int SPI_MAX_CHAR      = 32;
  localparam int SPI_CHAR_LEN_BITS = 6;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_SHIFT = 2'd1,
    ST_DONE  = 2'd2
  } spi_st_e;
endpackage

// File: rtl/spi_sync_edge.sv
// DEPTH-flop synchroniser for an asynchronous pin, plus one history flop for
// single-cycle rise/fall pulses on the synchronised level.
module spi_sync_edge #(
  parameter int DEPTH   = 2,
  parameter bit RST_VAL = 1'b0
) (
  input  logic wb_clk,
  input  logic wb_reset,
  input  logic d,
  output logic rise,
  output logic fall
);
  logic [DEPTH:0] q;

  always_ff @(posedge wb_clk or negedge wb_reset) begin
    if (!wb_reset) q <= {(DEPTH+1){RST_VAL}};
    else           q <= {q[DEPTH-1:0], d};
  end

  assign rise =  q[DEPTH-1] & ~q[DEPTH];
  assign fall = ~q[DEPTH-1] &  q[DEPTH];
endmodule

// File: rtl/spi_slave_shift.sv
// SPI slave shift engine: oversamples sclk/ss_n/mosi on wb_clk, deserialises
// mosi into rx_data and serialises a held tx word onto miso.
module spi_slave_shift
  import spi_slave_shift_pkg::*;
#(
  parameter int MAX_CHAR   = SPI_MAX_CHAR,
  parameter int LEN_BITS   = SPI_CHAR_LEN_BITS,
  parameter int SYNC_DEPTH = 2
) (
  input  logic                wb_clk,
  input  logic                wb_reset,
  input  logic                sclk,
  input  logic                ss_n,
  input  logic                mosi,
  output logic                miso,
  output logic                miso_oe,
  input  logic [LEN_BITS-1:0] len,
  input  logic                lsb,
  input  logic                rx_negedge,
  input  logic                tx_negedge,
  input  logic [MAX_CHAR-1:0] tx_data,
  input  logic                tx_valid,
  output logic                tx_ready,
  output logic [MAX_CHAR-1:0] rx_data,
  output logic                rx_valid,
  output logic                busy,
  output logic                abort,
  output logic                underrun
);
  localparam int CNT_W = $clog2(MAX_CHAR + 1);

  logic sclk_rise, sclk_fall, ss_rise, ss_fall;
  logic [SYNC_DEPTH-1:0] mosi_q;
  logic mosi_s;

  spi_sync_edge #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b0)) u_sclk_sync (
    .wb_clk(wb_clk), .wb_reset(wb_reset), .d(sclk), .rise(sclk_rise), .fall(sclk_fall));
  // ss_n resets high so release of reset never looks like a frame start
  spi_sync_edge #(.DEPTH(SYNC_DEPTH), .RST_VAL(1'b1)) u_ss_sync (
    .wb_clk(wb_clk), .wb_reset(wb_reset), .d(ss_n), .rise(ss_rise), .fall(ss_fall));

  always_ff @(posedge wb_clk or negedge wb_reset) begin
    if (!wb_reset) mosi_q <= '0;
    else           mosi_q <= {mosi_q[SYNC_DEPTH-2:0], mosi};
  end
  assign mosi_s = mosi_q[SYNC_DEPTH-1];

  spi_st_e             state, state_nx;
  logic [CNT_W-1:0]    cnt, frame_n, n_bits;
  logic [MAX_CHAR-1:0] hold, tx_shift, rx_shift, tx_load;
  logic                hold_full, lsb_q, first_tx, ss_low;
  logic                load, abort_p, rx_edge, tx_edge;
  logic [31:0]         len_ext;

  assign rx_edge = rx_negedge ? sclk_fall : sclk_rise;
  assign tx_edge = tx_negedge ? sclk_fall : sclk_rise;

  assign len_ext = 32'(len);
  assign n_bits  = (len_ext == 32'd0 || len_ext > MAX_CHAR) ? CNT_W'(MAX_CHAR) : CNT_W'(len_ext);
  // MSB-first words are top-aligned so the outgoing bit is always tx_shift[MAX_CHAR-1]
  assign tx_load = lsb ? hold : (hold << (MAX_CHAR - int'(n_bits)));

  always_comb begin
    state_nx = state;
    load     = 1'b0;
    abort_p  = 1'b0;
    case (state)
      ST_IDLE:
        if (ss_fall) begin
          state_nx = ST_SHIFT;
          load     = 1'b1;
        end
      ST_SHIFT:
        if (rx_edge && cnt == CNT_W'(1)) state_nx = ST_DONE;
        else if (ss_rise) begin
          state_nx = ST_IDLE;
          abort_p  = 1'b1;
        end
      ST_DONE:
        if (ss_low && !ss_rise) begin
          state_nx = ST_SHIFT;
          load     = 1'b1;
        end else state_nx = ST_IDLE;
      default: state_nx = ST_IDLE;
    endcase
  end

  always_ff @(posedge wb_clk or negedge wb_reset) begin
    if (!wb_reset) begin
      state     <= ST_IDLE;
      cnt       <= '0;
      frame_n   <= '0;
      lsb_q     <= 1'b0;
      first_tx  <= 1'b0;
      ss_low    <= 1'b0;
      hold      <= '0;
      hold_full <= 1'b0;
      tx_shift  <= '0;
      rx_shift  <= '0;
      rx_data   <= '0;
      rx_valid  <= 1'b0;
      abort     <= 1'b0;
      underrun  <= 1'b0;
    end else begin
      state    <= state_nx;
      rx_valid <= 1'b0;
      abort    <= abort_p;
      underrun <= 1'b0;
      if (ss_fall)      ss_low <= 1'b1;
      else if (ss_rise) ss_low <= 1'b0;

      if (tx_valid && !hold_full) begin
        hold      <= tx_data;
        hold_full <= 1'b1;
      end

      if (load) begin
        frame_n  <= n_bits;
        cnt      <= n_bits;
        lsb_q    <= lsb;
        first_tx <= 1'b1;
        rx_shift <= '0;
        if (hold_full) begin
          tx_shift  <= tx_load;
          hold_full <= 1'b0;
        end else begin
          tx_shift <= '0;
          underrun <= 1'b1;
        end
      end else if (state == ST_SHIFT) begin
        if (rx_edge) begin
          cnt <= cnt - CNT_W'(1);
          // LSB-first bits enter at the frame's top bit and walk down, ending right-aligned
          rx_shift <= lsb_q ? ((rx_shift >> 1) | ({{(MAX_CHAR-1){1'b0}}, mosi_s} << (frame_n - CNT_W'(1))))
                            : {rx_shift[MAX_CHAR-2:0], mosi_s};
        end
        if (tx_edge) begin
          if (first_tx) first_tx <= 1'b0;
          else          tx_shift <= lsb_q ? (tx_shift >> 1) : (tx_shift << 1);
        end
      end

      if (state == ST_DONE) begin
        rx_data  <= rx_shift;
        rx_valid <= 1'b1;
      end
    end
  end

  assign busy     = (state != ST_IDLE);
  assign miso_oe  = busy;
  assign miso     = busy & (lsb_q ? tx_shift[0] : tx_shift[MAX_CHAR-1]);
  assign tx_ready = ~hold_full;
endmodule

// File: tb/tb_spi_slave_shift.sv
// Bench for spi_slave_shift: behavioural SPI master drives pins, a word-level
// model predicts rx_data, miso word and pulse counts.
module tb_spi_slave_shift;
  localparam int MAXC = 32;
  localparam int LB   = 6;

  logic          wb_clk = 1'b0;
  logic          wb_reset, sclk, ss_n, mosi, miso, miso_oe;
  logic [LB-1:0] len;
  logic          lsb, rx_negedge, tx_negedge;
  logic [MAXC-1:0] tx_data, rx_data;
  logic          tx_valid, tx_ready, rx_valid, busy, abort, underrun;

  int n_err = 0, n_chk = 0;
  int n_rxv = 0, n_abt = 0, n_und = 0;

  spi_slave_shift dut (
    .wb_clk(wb_clk), .wb_reset(wb_reset), .sclk(sclk), .ss_n(ss_n), .mosi(mosi),
    .miso(miso), .miso_oe(miso_oe), .len(len), .lsb(lsb), .rx_negedge(rx_negedge),
    .tx_negedge(tx_negedge), .tx_data(tx_data), .tx_valid(tx_valid), .tx_ready(tx_ready),
    .rx_data(rx_data), .rx_valid(rx_valid), .busy(busy), .abort(abort), .underrun(underrun));

  always #5 wb_clk = ~wb_clk;

  always @(negedge wb_clk) begin
    if (rx_valid) n_rxv++;
    if (abort)    n_abt++;
    if (underrun) n_und++;
  end

  initial begin
    #3_000_000;
    $display("FAIL watchdog got=timeout exp=finish");
    $fatal(1, "watchdog");
  end

  task automatic chk(input string tag, input logic [63:0] got, input logic [63:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s got=%h exp=%h", tag, got, exp);
    end
  endtask

  task automatic clks(input int n);
    repeat (n) @(posedge wb_clk);
    #1;
  endtask

  function automatic int eff_n(input int l);
    return (l == 0 || l > MAXC) ? MAXC : l;
  endfunction

  function automatic logic [31:0] mask(input int n);
    logic [63:0] m;
    m = (64'd1 << n) - 64'd1;
    return m[31:0];
  endfunction

  function automatic logic seq_bit(input logic [31:0] w, input int n, input bit lb, input int k);
    return lb ? w[k] : w[n-1-k];
  endfunction

  task automatic push(input logic [31:0] w);
    int t = 0;
    while (!tx_ready && t < 200) begin clks(1); t++; end
    if (!tx_ready) chk("tx_ready_timeout", 0, 1);
    tx_data = w; tx_valid = 1'b1;
    clks(1);
    tx_valid = 1'b0;
  endtask

  task automatic start_frame(input int ln, input bit lb, input bit txn, input logic first_bit);
    len = LB'(ln); lsb = lb; tx_negedge = txn; rx_negedge = ~txn;
    sclk = txn;            // idle level chosen so the first edge is the tx edge
    clks(3);
    ss_n = 1'b0; mosi = first_bit;
    clks(4);
  endtask

  // stop_at >= 0 raises ss_n after that many complete bits
  task automatic bits(input int n, input bit lb, input logic [31:0] mw, input int stop_at,
                      input bit raise, output logic [31:0] got);
    got = '0;
    for (int k = 0; k < n; k++) begin
      if (k == stop_at) begin ss_n = 1'b1; return; end
      sclk = ~sclk; mosi = seq_bit(mw, n, lb, k);
      clks(5);
      if (lb) got[k] = miso; else got[n-1-k] = miso;
      sclk = ~sclk;
      if (raise && k == n-1) ss_n = 1'b1;
      clks(5);
    end
  endtask

  task automatic frame_check(input string tag, input int ln, input bit lb, input bit txn,
                             input logic [31:0] mw, input bit pushed, input logic [31:0] tw);
    int n, b_rxv, b_und;
    logic [31:0] got;
    n = eff_n(ln); b_rxv = n_rxv; b_und = n_und;
    if (pushed) push(tw);
    start_frame(ln, lb, txn, seq_bit(mw, n, lb, 0));
    chk({tag, "_oe"}, miso_oe, 1);
    bits(n, lb, mw, -1, 1'b1, got);
    clks(6);
    chk({tag, "_rx"}, rx_data, mw & mask(n));
    chk({tag, "_miso"}, got, pushed ? (tw & mask(n)) : 32'd0);
    chk({tag, "_rxv"}, n_rxv - b_rxv, 1);
    chk({tag, "_und"}, n_und - b_und, pushed ? 0 : 1);
    chk({tag, "_busy"}, busy, 0);
  endtask

  initial begin
    logic [31:0] got, old;
    int b_rxv, b_abt;
    wb_reset = 1'b0; sclk = 1'b0; ss_n = 1'b1; mosi = 1'b0; len = '0; lsb = 1'b0;
    rx_negedge = 1'b0; tx_negedge = 1'b1; tx_data = '0; tx_valid = 1'b0;
    clks(3);
    chk("rst_miso", miso, 0);     chk("rst_oe", miso_oe, 0);
    chk("rst_ready", tx_ready, 1); chk("rst_rx", rx_data, 0);
    chk("rst_rxv", rx_valid, 0);  chk("rst_busy", busy, 0);
    chk("rst_abort", abort, 0);   chk("rst_und", underrun, 0);
    wb_reset = 1'b1;
    clks(3);

    frame_check("basic", 8, 1'b0, 1'b1, 32'h3C, 1'b1, 32'hA5);
    frame_check("full_lsb", 0, 1'b1, 1'b1, 32'hAA55_1234, 1'b1, 32'h1357_9BDF);
    frame_check("underrun", 8, 1'b0, 1'b1, 32'hC3, 1'b0, 32'h0);
    frame_check("sat", 45, 1'b0, 1'b0, 32'h8001_F00D, 1'b1, 32'hDEAD_BEEF);
    frame_check("len1", 1, 1'b1, 1'b0, 32'h1, 1'b1, 32'h1);

    // abort after 3 of 8 bits
    old = rx_data; b_rxv = n_rxv; b_abt = n_abt;
    push(32'h96);
    start_frame(8, 1'b0, 1'b1, 1'b1);
    bits(8, 1'b0, 32'hF0, 3, 1'b0, got);
    clks(8);
    chk("abort_cnt", n_abt - b_abt, 1);
    chk("abort_rxv", n_rxv - b_rxv, 0);
    chk("abort_rx", rx_data, old);
    chk("abort_oe", miso_oe, 0);
    chk("abort_miso", miso, 0);

    // back-to-back frames with ss_n held low
    b_rxv = n_rxv;
    push(32'h77);
    start_frame(8, 1'b0, 1'b1, 1'b0);
    push(32'h88);
    bits(8, 1'b0, 32'h11, -1, 1'b0, got);
    chk("b2b_rx1", rx_data, 32'h11);
    chk("b2b_miso1", got, 32'h77);
    chk("b2b_busy", busy, 1);
    bits(8, 1'b0, 32'h22, -1, 1'b1, got);
    clks(6);
    chk("b2b_rx2", rx_data, 32'h22);
    chk("b2b_miso2", got, 32'h88);
    chk("b2b_rxv", n_rxv - b_rxv, 2);

    // sclk activity with ss_n high is ignored
    b_rxv = n_rxv;
    for (int i = 0; i < 8; i++) begin sclk = ~sclk; clks(5); end
    chk("idle_busy", busy, 0);
    chk("idle_rxv", n_rxv - b_rxv, 0);

    // async reset mid-frame
    push(32'h3);
    start_frame(8, 1'b0, 1'b1, 1'b1);
    bits(8, 1'b0, 32'hFF, 4, 1'b0, got);
    ss_n = 1'b0;
    chk("mid_busy", busy, 1);
    wb_reset = 1'b0; #2;
    chk("mr_busy", busy, 0);  chk("mr_oe", miso_oe, 0);
    chk("mr_miso", miso, 0);  chk("mr_ready", tx_ready, 1);
    chk("mr_rx", rx_data, 0); chk("mr_rxv", rx_valid, 0);
    ss_n = 1'b1; sclk = 1'b1;
    clks(3);
    wb_reset = 1'b1;
    clks(3);
    frame_check("after_rst", 8, 1'b0, 1'b1, 32'h5A, 1'b1, 32'hE1);

    for (int i = 0; i < 12; i++) begin
      frame_check($sformatf("rnd%0d", i), int'($urandom_range(0, 63)), 1'($urandom),
                  1'($urandom), $urandom, ($urandom_range(0, 3) != 0), $urandom);
    end

    $display("Result: errors=%0d of %0d checks", n_err, n_chk);
    $finish;
  end
endmodule
